// File: rtl/lsu_pkg.sv
// Shared encodings and helpers for the load/store unit.
package lsu_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] ACCESS  = 3'd1;
    localparam logic [2:0] CAPTURE = 3'd2;
    localparam logic [2:0] WRITE   = 3'd3;
    localparam logic [2:0] RESP    = 3'd4;

    // Size 11 has no legal alignment, so it is always rejected.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lsb);
        logic bad;
        case (size)
            SIZE_B:  bad = 1'b0;
            SIZE_H:  bad = lsb[0];
            SIZE_W:  bad = (lsb != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_lane.sv
// Byte-lane steering: extracts/extends a load lane and merges store data into a word.
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    output logic [31:0] load_val,
    output logic [31:0] merged
);

    logic [4:0]  sh_b;
    logic [4:0]  sh_h;
    logic [31:0] word_sh;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        sh_b     = {addr, 3'b000};
        sh_h     = {addr[1], 4'b0000};
        word_sh  = word >> sh_b;
        byte_v   = word_sh[7:0];
        half_v   = addr[1] ? word[31:16] : word[15:0];
        load_val = word;
        merged   = wdata;
        case (size)
            SIZE_B: begin
                load_val = {{24{~is_unsigned & byte_v[7]}}, byte_v};
                merged   = (word & ~(32'h0000_00FF << sh_b)) | ({24'h0, wdata[7:0]} << sh_b);
            end
            SIZE_H: begin
                load_val = {{16{~is_unsigned & half_v[15]}}, half_v};
                merged   = (word & ~(32'h0000_FFFF << sh_h)) | ({16'h0, wdata[15:0]} << sh_h);
            end
            default: begin
                load_val = word;
                merged   = wdata;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Byte/half/word load-store front end for a word-addressed SPRAM without byte enables.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_AW = 14
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    output logic        mem_memwrite,
    output logic        mem_memread,
    input  logic [31:0] mem_read_data
);

    logic [2:0]        state_q, state_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [MEM_AW+1:0] addr_q, addr_d;
    logic              err_q, err_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [31:0]       mwdata_q, mwdata_d;

    logic [31:0] lane_load;
    logic [31:0] lane_merged;
    logic        word_store;
    logic        addr_hi_unused;

    // Upper byte-address bits alias onto the same memory words.
    assign addr_hi_unused = ^req_addr[31:MEM_AW+2];

    lsu_lane u_lane (
        .word        (mem_read_data),
        .addr        (addr_q[1:0]),
        .size        (size_q),
        .is_unsigned (uns_q),
        .wdata       (mwdata_q),
        .load_val    (lane_load),
        .merged      (lane_merged)
    );

    assign word_store = we_q && (size_q == SIZE_W);

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        size_d   = size_q;
        uns_d    = uns_q;
        addr_d   = addr_q;
        err_d    = err_q;
        rdata_d  = rdata_q;
        mwdata_d = mwdata_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d     = req_we;
                    size_d   = req_size;
                    uns_d    = req_unsigned;
                    addr_d   = req_addr[MEM_AW+1:0];
                    mwdata_d = req_wdata;
                    rdata_d  = 32'h0;
                    err_d    = is_misaligned(req_size, req_addr[1:0]);
                    state_d  = err_d ? RESP : ACCESS;
                end
            end
            ACCESS:  state_d = word_store ? RESP : CAPTURE;
            CAPTURE: begin
                // mwdata_q is reused to carry the merged word into WRITE.
                if (we_q) begin
                    mwdata_d = lane_merged;
                    state_d  = WRITE;
                end else begin
                    rdata_d  = lane_load;
                    state_d  = RESP;
                end
            end
            WRITE:   state_d = RESP;
            RESP:    if (resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            size_q   <= SIZE_B;
            uns_q    <= 1'b0;
            addr_q   <= '0;
            err_q    <= 1'b0;
            rdata_q  <= 32'h0;
            mwdata_q <= 32'h0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            size_q   <= size_d;
            uns_q    <= uns_d;
            addr_q   <= addr_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
            mwdata_q <= mwdata_d;
        end
    end

    assign req_ready      = (state_q == IDLE);
    assign resp_valid     = (state_q == RESP);
    assign resp_err       = resp_valid & err_q;
    assign resp_rdata     = rdata_q;
    assign mem_addr       = {{(32-MEM_AW){1'b0}}, addr_q[MEM_AW+1:2]};
    assign mem_write_data = mwdata_q;
    assign mem_memwrite   = ((state_q == ACCESS) && word_store) || (state_q == WRITE);
    assign mem_memread    = (state_q == ACCESS) && !word_store;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed table, hand sequences, and randomized ops against a byte-array model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata, mem_addr, mem_write_data, mem_read_data;
    logic        mem_memwrite, mem_memread;

    always #5 clk = ~clk;

    load_store_unit #(.MEM_AW(14)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_we         (req_we),
        .req_size       (req_size),
        .req_unsigned   (req_unsigned),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_rdata     (resp_rdata),
        .resp_err       (resp_err),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_memwrite   (mem_memwrite),
        .mem_memread    (mem_memread),
        .mem_read_data  (mem_read_data)
    );

    // Word-addressed SPRAM with a registered read.
    logic [31:0] mem [0:16383];
    int          n_strobe = 0;
    int          n_writes = 0;
    int          n_both   = 0;
    logic [31:0] last_waddr = 32'h0;
    logic [31:0] last_wdata = 32'h0;

    always @(posedge clk) begin
        if (mem_memwrite) begin
            mem[mem_addr[13:0]] <= mem_write_data;
            last_waddr <= mem_addr;
            last_wdata <= mem_write_data;
            n_writes   <= n_writes + 1;
        end
        if (mem_memread) mem_read_data <= mem[mem_addr[13:0]];
        if (mem_memread || mem_memwrite) n_strobe <= n_strobe + 1;
        if (mem_memread && mem_memwrite) n_both <= n_both + 1;
    end

    // Reference model: a flat little-endian byte array for the low 256 bytes.
    logic [7:0] rmem [0:255];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic ref_op(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output logic er, output int lat);
        int n;
        int base;
        n    = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 4 : 0;
        base = int'(a[7:0]);
        rd   = 32'h0;
        er   = (n == 0) ? 1'b1 : ((base % n) != 0);
        lat  = 1;
        if (!er && we) begin
            for (int i = 0; i < n; i++) rmem[base+i] = wd[8*i +: 8];
            lat = (n == 4) ? 2 : 4;
        end else if (!er) begin
            for (int i = 0; i < n; i++) rd = rd | (32'(rmem[base+i]) << (8*i));
            if (!uns && n < 4 && rd[8*n-1]) rd = rd | ~((32'h1 << (8*n)) - 32'h1);
            lat = 3;
        end
    endtask

    task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd, input bit hold,
                          output logic [31:0] rd, output logic er, output int lat);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = a; req_wdata = wd;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        rd = resp_rdata;
        er = resp_err;
        chk("busy_during_resp", {31'h0, req_ready}, 32'h0);
        if (!hold) @(posedge clk);
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        er;
        int          lat;
    } vec_t;

    vec_t tbl [16];

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd, exp_rd;
        logic        er, exp_er;
        int          lat, exp_lat, s0, w0;

        for (int i = 0; i < 16384; i++) mem[i] = 32'h0;
        for (int i = 0; i < 256; i++) rmem[i] = 8'h0;
        mem_read_data = 32'h0;
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b1;

        #1;
        chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
        chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("rst_resp_err", {31'h0, resp_err}, 32'h0);
        chk("rst_strobes", {30'h0, mem_memread, mem_memwrite}, 32'h0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_write_data, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        tbl[0]  = '{1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2};
        tbl[1]  = '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 3};
        tbl[2]  = '{1'b1, 2'd1, 1'b0, 32'h12, 32'h1234ABCD, 32'h0, 1'b0, 4};
        tbl[3]  = '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'hABCDBEEF, 1'b0, 3};
        tbl[4]  = '{1'b1, 2'd2, 1'b0, 32'h10, 32'h80FF7F01, 32'h0, 1'b0, 2};
        tbl[5]  = '{1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 32'hFFFFFF80, 1'b0, 3};
        tbl[6]  = '{1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 32'h00000080, 1'b0, 3};
        tbl[7]  = '{1'b0, 2'd0, 1'b0, 32'h11, 32'h0, 32'h0000007F, 1'b0, 3};
        tbl[8]  = '{1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 32'hFFFF80FF, 1'b0, 3};
        tbl[9]  = '{1'b0, 2'd1, 1'b1, 32'h10, 32'h0, 32'h00007F01, 1'b0, 3};
        tbl[10] = '{1'b0, 2'd1, 1'b0, 32'h11, 32'h0, 32'h0, 1'b1, 1};
        tbl[11] = '{1'b0, 2'd2, 1'b0, 32'h12, 32'h0, 32'h0, 1'b1, 1};
        tbl[12] = '{1'b1, 2'd3, 1'b0, 32'h10, 32'h5, 32'h0, 1'b1, 1};
        tbl[13] = '{1'b1, 2'd1, 1'b0, 32'h13, 32'hFFFF, 32'h0, 1'b1, 1};
        tbl[14] = '{1'b1, 2'd0, 1'b0, 32'h12, 32'hAA, 32'h0, 1'b0, 4};
        tbl[15] = '{1'b0, 2'd2, 1'b0, 32'h00010010, 32'h0, 32'h80AA7F01, 1'b0, 3};

        for (int i = 0; i < 16; i++) begin
            ref_op(tbl[i].we, tbl[i].sz, tbl[i].uns, tbl[i].a, tbl[i].wd, exp_rd, exp_er, exp_lat);
            s0 = n_strobe;
            do_req(tbl[i].we, tbl[i].sz, tbl[i].uns, tbl[i].a, tbl[i].wd, 1'b0, rd, er, lat);
            chk($sformatf("vec%0d_rdata", i), rd, tbl[i].rd);
            chk($sformatf("vec%0d_err", i), {31'h0, er}, {31'h0, tbl[i].er});
            chk($sformatf("vec%0d_latency", i), lat, tbl[i].lat);
            if (tbl[i].er) chk($sformatf("vec%0d_no_strobe", i), n_strobe - s0, 0);
            if (i == 0) begin
                chk("wstore_addr", last_waddr, 32'h4);
                chk("wstore_data", last_wdata, 32'hDEADBEEF);
            end
            if (i == 2) chk("hstore_merged", last_wdata, 32'hABCDBEEF);
        end

        // Backpressure: response must hold while the consumer stalls.
        resp_ready = 1'b0;
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1, rd, er, lat);
        chk("bp_first_rdata", rd, 32'h80AA7F01);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("bp_valid_%0d", k), {31'h0, resp_valid}, 32'h1);
            chk($sformatf("bp_rdata_%0d", k), resp_rdata, 32'h80AA7F01);
            chk($sformatf("bp_ready_%0d", k), {31'h0, req_ready}, 32'h0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_released_valid", {31'h0, resp_valid}, 32'h0);
        chk("bp_released_ready", {31'h0, req_ready}, 32'h1);

        // Reset during CAPTURE of a byte store: no write may follow.
        w0 = n_writes;
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 32'h10; req_wdata = 32'h55;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("rmw_access_read", {31'h0, mem_memread}, 32'h1);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rmw_rst_strobes", {30'h0, mem_memread, mem_memwrite}, 32'h0);
        chk("rmw_rst_ready", {31'h0, req_ready}, 32'h1);
        chk("rmw_rst_valid", {31'h0, resp_valid}, 32'h0);
        chk("rmw_rst_wdata", mem_write_data, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("rmw_mem_unchanged", mem[4], 32'h80AA7F01);
        chk("rmw_no_write", n_writes - w0, 0);
        chk("rmw_ready_after", {31'h0, req_ready}, 32'h1);

        // Reset while a word write strobe is up drops it asynchronously.
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = 32'h10; req_wdata = 32'h11111111;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("wr_access_strobe", {31'h0, mem_memwrite}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("wr_rst_strobe", {31'h0, mem_memwrite}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("wr_mem_unchanged", mem[4], 32'h80AA7F01);

        // Randomized traffic against the byte-array model.
        for (int t = 0; t < 300; t++) begin
            logic        rwe, runs;
            logic [1:0]  rsz;
            logic [31:0] ra, rwd;
            rwe  = 1'($urandom_range(0, 1));
            runs = 1'($urandom_range(0, 1));
            rsz  = 2'($urandom_range(0, 3));
            ra   = {$urandom_range(0, 65535) << 16} | 32'($urandom_range(0, 255));
            rwd  = $urandom;
            ref_op(rwe, rsz, runs, ra, rwd, exp_rd, exp_er, exp_lat);
            s0 = n_strobe;
            do_req(rwe, rsz, runs, ra, rwd, 1'b0, rd, er, lat);
            chk($sformatf("rnd%0d_rdata", t), rd, exp_rd);
            chk($sformatf("rnd%0d_err", t), {31'h0, er}, {31'h0, exp_er});
            chk($sformatf("rnd%0d_latency", t), lat, exp_lat);
            if (exp_er) chk($sformatf("rnd%0d_no_strobe", t), n_strobe - s0, 0);
        end

        repeat (2) @(negedge clk);
        for (int w = 0; w < 64; w++)
            chk($sformatf("mem_word_%0d", w), mem[w],
                {rmem[4*w+3], rmem[4*w+2], rmem[4*w+1], rmem[4*w]});
        chk("read_write_exclusive", n_both, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
